matrix_scan: RTL and testbench

//  Consumes 16-bit column patterns and drives a row-multiplexed LED dot matrix.

---
 rtl/matrix_scan_if.sv | 28 ++
 rtl/matrix_scan.sv | 110 +++++++++++
 tb/tb_matrix_scan.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_scan_if.sv
// Pattern-source / display-drive bundle for matrix_scan.
// master: pattern source and display controller; slave: the scanner itself.
interface matrix_scan_if #(
  parameter int unsigned ROWS = 16,
  parameter int unsigned COLS = 16
);
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic             scan_en;
  logic             wr_en;
  logic [ROW_W-1:0] wr_row;
  logic [COLS-1:0]  wr_data;
  logic             swap_req;
  logic [ROWS-1:0]  row_sel;
  logic [COLS-1:0]  col_out;
  logic             frame_start;
  logic             swap_done;

  modport master (
    output scan_en, wr_en, wr_row, wr_data, swap_req,
    input  row_sel, col_out, frame_start, swap_done
  );

  modport slave (
    input  scan_en, wr_en, wr_row, wr_data, swap_req,
    output row_sel, col_out, frame_start, swap_done
  );
endinterface

// File: rtl/matrix_scan.sv
// Row-multiplexed LED matrix scanner with a double-buffered frame store.
// The front buffer is scanned row by row with a blanking gap at the start of
// each dwell; the pattern source only ever writes the back buffer, and the two
// are exchanged at a frame boundary so a torn frame is never displayed.
module matrix_scan #(
  parameter int unsigned ROWS     = 16,
  parameter int unsigned COLS     = 16,
  parameter int unsigned SCAN_DIV = 256,
  parameter int unsigned BLANK    = 8
) (
  input logic          clk,
  input logic          rst,
  matrix_scan_if.slave bus
);
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [ROW_W-1:0] RowLast  = ROW_W'(ROWS - 1);
  localparam logic [DIV_W-1:0] DivLast  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BlankEnd = DIV_W'(BLANK);
  localparam logic [ROWS-1:0]  RowOne   = ROWS'(1);

  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             front_q, front_d;
  logic             swap_pend_q, swap_pend_d;
  logic [ROWS-1:0]  row_sel_q, row_sel_d;
  logic [COLS-1:0]  col_out_q, col_out_d;
  logic             frame_start_q, frame_start_d;
  logic             swap_done_q, swap_done_d;
  logic             boundary;
  logic             do_swap;
  logic             wr_hit;

  // Frame store: index 0/1 selects the buffer, front_q names the displayed one.
  logic [1:0][ROWS-1:0][COLS-1:0] fb_q;

  assign wr_hit = bus.wr_en && (32'(bus.wr_row) < ROWS);

  // Next-state: scan counters, registered output phase, swap arbitration.
  always_comb begin
    row_cnt_d     = row_cnt_q;
    div_cnt_d     = div_cnt_q;
    row_sel_d     = '1;
    col_out_d     = '0;
    frame_start_d = 1'b0;
    boundary      = 1'b0;

    if (bus.scan_en) begin
      if (div_cnt_q >= BlankEnd) begin
        row_sel_d = ~(RowOne << row_cnt_q);
        col_out_d = fb_q[front_q][row_cnt_q];
      end
      frame_start_d = (row_cnt_q == '0) && (div_cnt_q == '0);
      if (div_cnt_q == DivLast) begin
        div_cnt_d = '0;
        boundary  = (row_cnt_q == RowLast);
        row_cnt_d = boundary ? '0 : row_cnt_q + ROW_W'(1);
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end else begin
      row_cnt_d = '0;
      div_cnt_d = '0;
    end

    // While disabled nothing is on screen, so a swap can apply immediately.
    do_swap     = (swap_pend_q || bus.swap_req) && (boundary || !bus.scan_en);
    front_d     = front_q ^ do_swap;
    swap_pend_d = (swap_pend_q || bus.swap_req) && !do_swap;
    swap_done_d = do_swap;
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_cnt_q     <= '0;
      div_cnt_q     <= '0;
      front_q       <= 1'b0;
      swap_pend_q   <= 1'b0;
      row_sel_q     <= '1;
      col_out_q     <= '0;
      frame_start_q <= 1'b0;
      swap_done_q   <= 1'b0;
    end else begin
      row_cnt_q     <= row_cnt_d;
      div_cnt_q     <= div_cnt_d;
      front_q       <= front_d;
      swap_pend_q   <= swap_pend_d;
      row_sel_q     <= row_sel_d;
      col_out_q     <= col_out_d;
      frame_start_q <= frame_start_d;
      swap_done_q   <= swap_done_d;
    end
  end

  // Back-buffer write; uses the pre-swap front so a coincident write joins the new frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fb_q <= '0;
    end else if (wr_hit) begin
      fb_q[~front_q][bus.wr_row] <= bus.wr_data;
    end
  end

  assign bus.row_sel     = row_sel_q;
  assign bus.col_out     = col_out_q;
  assign bus.frame_start = frame_start_q;
  assign bus.swap_done   = swap_done_q;
endmodule

// File: tb/tb_matrix_scan.sv
// Scoreboard bench for matrix_scan: a frame-level model predicts every output
// cycle, pushes it when stimulus is driven, and each test pops and compares.
module tb_matrix_scan;
  localparam int unsigned ROWS     = 16;
  localparam int unsigned COLS     = 16;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned BLANK    = 1;
  localparam int unsigned FRAME    = ROWS * SCAN_DIV;
  localparam int unsigned ROWS2    = 12;

  typedef struct {
    logic [15:0] row_sel;
    logic [15:0] col;
    logic        fs;
    logic        sd;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  exp_t        sb[$];
  logic [15:0] m_disp[ROWS];
  logic [15:0] m_back[ROWS];
  bit          m_pend;
  int          m_n;

  always #5 clk = ~clk;

  matrix_scan_if #(.ROWS(ROWS), .COLS(COLS)) bus ();
  matrix_scan #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .BLANK(BLANK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  matrix_scan_if #(.ROWS(ROWS2), .COLS(COLS)) bus2 ();
  matrix_scan #(.ROWS(ROWS2), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .BLANK(BLANK)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++) begin
      m_disp[r] = '0;
      m_back[r] = '0;
    end
    m_pend = 1'b0;
    m_n    = 0;
    sb.delete();
  endtask

  // Drive one cycle on the main DUT, push the predicted output, advance model.
  task automatic drive(input bit en, input bit we, input logic [3:0] row,
                       input logic [15:0] data, input bit req);
    exp_t        e;
    int          r;
    int          d;
    bit          sw;
    logic [15:0] t;
    bus.scan_en  = en;
    bus.wr_en    = we;
    bus.wr_row   = row;
    bus.wr_data  = data;
    bus.swap_req = req;
    e = '{16'hFFFF, 16'h0000, 1'b0, 1'b0};
    if (en) begin
      r = (m_n / SCAN_DIV) % ROWS;
      d = m_n % SCAN_DIV;
      if (d >= BLANK) begin
        e.row_sel = ~(16'h0001 << r);
        e.col     = m_disp[r];
      end
      e.fs = ((m_n % FRAME) == 0);
      sw   = (m_pend || req) && ((m_n % FRAME) == FRAME - 1);
      m_n++;
    end else begin
      sw  = m_pend || req;
      m_n = 0;
    end
    e.sd = sw;
    if (we) m_back[row] = data;
    if (sw) begin
      for (int k = 0; k < ROWS; k++) begin
        t         = m_disp[k];
        m_disp[k] = m_back[k];
        m_back[k] = t;
      end
      m_pend = 1'b0;
    end else begin
      m_pend = m_pend || req;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.scan_en = 0; bus.wr_en = 0; bus.wr_row = '0; bus.wr_data = '0; bus.swap_req = 0;
    bus2.scan_en = 0; bus2.wr_en = 0; bus2.wr_row = '0; bus2.wr_data = '0; bus2.swap_req = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.row_sel !== 16'hFFFF || bus.col_out !== 16'h0000 ||
        bus.frame_start !== 1'b0 || bus.swap_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state row_sel=%h col_out=%h fs=%b sd=%b required FFFF 0000 0 0",
               bus.row_sel, bus.col_out, bus.frame_start, bus.swap_done);
    end
    checks++;
    if (bus2.row_sel !== 12'hFFF || bus2.col_out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state2 row_sel=%h col_out=%h required FFF 0000",
               bus2.row_sel, bus2.col_out);
    end
    rst = 1'b1;
  endtask

  task automatic test_scan_timing();
    exp_t e;
    int   fs_seen = 0;
    for (int i = 0; i < 2 + FRAME + 5; i++) begin
      drive(i >= 2, 1'b0, 4'd0, 16'h0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (bus.row_sel !== e.row_sel || bus.col_out !== e.col ||
          bus.frame_start !== e.fs || bus.swap_done !== e.sd) begin
        failures++;
        $display("FAIL scan_timing i=%0d row_sel=%h/%h col=%h/%h fs=%b/%b sd=%b/%b (got/required)",
                 i, bus.row_sel, e.row_sel, bus.col_out, e.col, bus.frame_start, e.fs,
                 bus.swap_done, e.sd);
      end
      if (bus.frame_start === 1'b1) fs_seen++;
    end
    checks++;
    if (fs_seen != 2) begin
      failures++;
      $display("FAIL scan_frame_period frame_start count=%0d required 2", fs_seen);
    end
  endtask

  task automatic test_swap_boundary();
    exp_t        e;
    int          sd_seen = 0;
    logic [15:0] r3 = 16'hxxxx;
    for (int i = 0; i < 2 * FRAME; i++) begin
      drive(1'b1, i < 16, 4'(i), 16'h0001 << (i % 16), i == 20);
      e = sb.pop_front();
      checks++;
      if (bus.row_sel !== e.row_sel || bus.col_out !== e.col ||
          bus.frame_start !== e.fs || bus.swap_done !== e.sd) begin
        failures++;
        $display("FAIL swap_boundary i=%0d row_sel=%h/%h col=%h/%h fs=%b/%b sd=%b/%b (got/required)",
                 i, bus.row_sel, e.row_sel, bus.col_out, e.col, bus.frame_start, e.fs,
                 bus.swap_done, e.sd);
      end
      if (bus.swap_done === 1'b1) sd_seen++;
      if (sd_seen > 0 && bus.row_sel === 16'hFFF7) r3 = bus.col_out;
    end
    checks++;
    if (sd_seen != 1) begin
      failures++;
      $display("FAIL swap_done_once count=%0d required 1", sd_seen);
    end
    checks++;
    if (r3 !== 16'h0008) begin
      failures++;
      $display("FAIL swap_row3 col_out=%h required 0008", r3);
    end
  endtask

  task automatic test_write_swap_coincide();
    exp_t        e;
    int          sd_seen = 0;
    bit          hit = 0;
    bit          at_b;
    logic [15:0] r0 = 16'hxxxx;
    for (int i = 0; i < 3 * FRAME; i++) begin
      at_b = !hit && ((m_n % FRAME) == FRAME - 1);
      drive(1'b1, at_b, 4'd0, 16'hA5A5, at_b);
      if (at_b) hit = 1;
      e = sb.pop_front();
      checks++;
      if (bus.row_sel !== e.row_sel || bus.col_out !== e.col ||
          bus.frame_start !== e.fs || bus.swap_done !== e.sd) begin
        failures++;
        $display("FAIL coincide i=%0d row_sel=%h/%h col=%h/%h fs=%b/%b sd=%b/%b (got/required)",
                 i, bus.row_sel, e.row_sel, bus.col_out, e.col, bus.frame_start, e.fs,
                 bus.swap_done, e.sd);
      end
      if (bus.swap_done === 1'b1) sd_seen++;
      if (sd_seen > 0 && bus.row_sel === 16'hFFFE) r0 = bus.col_out;
      if (hit && (m_n % FRAME) == 2 * SCAN_DIV) break;
    end
    checks++;
    if (sd_seen != 1) begin
      failures++;
      $display("FAIL coincide_swap_done count=%0d required 1", sd_seen);
    end
    checks++;
    if (r0 !== 16'hA5A5) begin
      failures++;
      $display("FAIL coincide_row0 col_out=%h required A5A5", r0);
    end
  endtask

  task automatic test_disable();
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      drive(i >= 4, 1'b0, 4'd0, 16'h0, i == 2);
      e = sb.pop_front();
      checks++;
      if (bus.row_sel !== e.row_sel || bus.col_out !== e.col ||
          bus.frame_start !== e.fs || bus.swap_done !== e.sd) begin
        failures++;
        $display("FAIL disable i=%0d row_sel=%h/%h col=%h/%h fs=%b/%b sd=%b/%b (got/required)",
                 i, bus.row_sel, e.row_sel, bus.col_out, e.col, bus.frame_start, e.fs,
                 bus.swap_done, e.sd);
      end
      if (i == 2) begin
        checks++;
        if (bus.swap_done !== 1'b1) begin
          failures++;
          $display("FAIL disable_swap swap_done=%b required 1", bus.swap_done);
        end
      end
      if (i == 4) begin
        checks++;
        if (bus.frame_start !== 1'b1 || bus.row_sel !== 16'hFFFF) begin
          failures++;
          $display("FAIL reenable fs=%b row_sel=%h required 1 FFFF",
                   bus.frame_start, bus.row_sel);
        end
      end
    end
  endtask

  task automatic test_back_only();
    exp_t        e;
    bit          wrote = 0;
    bit          asked = 0;
    bit          we;
    bit          rq;
    int          sd_seen = 0;
    logic [15:0] pre_exp;
    logic [15:0] pre = 16'hxxxx;
    logic [15:0] post = 16'hxxxx;
    pre_exp = m_disp[0];
    for (int i = 0; i < 3 * FRAME; i++) begin
      we = !wrote && ((m_n % FRAME) == 1);
      rq = wrote && !asked && ((m_n % FRAME) == 40);
      drive(1'b1, we, 4'd0, 16'h3C3C, rq);
      if (we) wrote = 1;
      if (rq) asked = 1;
      e = sb.pop_front();
      checks++;
      if (bus.row_sel !== e.row_sel || bus.col_out !== e.col ||
          bus.frame_start !== e.fs || bus.swap_done !== e.sd) begin
        failures++;
        $display("FAIL back_only i=%0d row_sel=%h/%h col=%h/%h fs=%b/%b sd=%b/%b (got/required)",
                 i, bus.row_sel, e.row_sel, bus.col_out, e.col, bus.frame_start, e.fs,
                 bus.swap_done, e.sd);
      end
      if (bus.swap_done === 1'b1) sd_seen++;
      if (wrote && sd_seen == 0 && bus.row_sel === 16'hFFFE) pre = bus.col_out;
      if (sd_seen > 0 && bus.row_sel === 16'hFFFE) post = bus.col_out;
    end
    checks++;
    if (pre !== pre_exp) begin
      failures++;
      $display("FAIL back_only_pre col_out=%h required %h", pre, pre_exp);
    end
    checks++;
    if (post !== 16'h3C3C) begin
      failures++;
      $display("FAIL back_only_post col_out=%h required 3C3C", post);
    end
  endtask

  task automatic test_out_of_range();
    logic [15:0] q[$];
    logic [15:0] x;
    int          r;
    int          d;
    // Rows 12 and 15 do not exist on the 12-row instance; row 11 does.
    bus2.wr_en = 1'b1;
    bus2.wr_row = 4'd12; bus2.wr_data = 16'hFFFF; @(posedge clk); #1;
    bus2.wr_row = 4'd15; bus2.wr_data = 16'hFFFF; @(posedge clk); #1;
    bus2.wr_row = 4'd11; bus2.wr_data = 16'h0800; @(posedge clk); #1;
    bus2.wr_en = 1'b0;
    bus2.swap_req = 1'b1; @(posedge clk); #1;
    bus2.swap_req = 1'b0;
    checks++;
    if (bus2.swap_done !== 1'b1) begin
      failures++;
      $display("FAIL oor_swap swap_done=%b required 1", bus2.swap_done);
    end
    bus2.scan_en = 1'b1;
    for (int n = 0; n < ROWS2 * SCAN_DIV; n++) begin
      r = n / SCAN_DIV;
      d = n % SCAN_DIV;
      q.push_back((d >= BLANK && r == 11) ? 16'h0800 : 16'h0000);
      @(posedge clk);
      #1;
      x = q.pop_front();
      checks++;
      if (bus2.col_out !== x) begin
        failures++;
        $display("FAIL out_of_range n=%0d col_out=%h required %h", n, bus2.col_out, x);
      end
    end
    bus2.scan_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int i = 0; i < 21; i++) begin
      drive(1'b1, 1'b0, 4'd0, 16'h0, 1'b0);
      e = sb.pop_front();
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.row_sel !== 16'hFFFF || bus.col_out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_async row_sel=%h col_out=%h required FFFF 0000",
               bus.row_sel, bus.col_out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.row_sel !== 16'hFFFF || bus.col_out !== 16'h0000 ||
        bus.frame_start !== 1'b0 || bus.swap_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid row_sel=%h col_out=%h fs=%b sd=%b required FFFF 0000 0 0",
               bus.row_sel, bus.col_out, bus.frame_start, bus.swap_done);
    end
    rst = 1'b1;
    model_reset();
    // Both buffers must read back empty: scan one frame, swap, scan another.
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      drive(1'b1, 1'b0, 4'd0, 16'h0, i == 5);
      e = sb.pop_front();
      checks++;
      if (bus.row_sel !== e.row_sel || bus.col_out !== e.col ||
          bus.frame_start !== e.fs || bus.swap_done !== e.sd) begin
        failures++;
        $display("FAIL reset_clear i=%0d row_sel=%h/%h col=%h/%h fs=%b/%b sd=%b/%b (got/required)",
                 i, bus.row_sel, e.row_sel, bus.col_out, e.col, bus.frame_start, e.fs,
                 bus.swap_done, e.sd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_timing();
    test_swap_boundary();
    test_write_swap_coincide();
    test_disable();
    test_back_only();
    test_out_of_range();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
